// File: rtl/fpu_mac_seq.sv
// fpu_mac_seq: sequential bfloat16 multiply-accumulate that shares one external combinational FPU
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, len_i           begin an accumulation of len_i pairs (sampled in IDLE)
//   pair_valid_i/ready_o     operand pair handshake carrying a_i, b_i
//   fpu_mode_o, fpu_in*_o    drive the FPU; fpu_out_i/fpu_overflow_i return its result
//   res_valid_o/ready_i      result handshake carrying res_o, res_overflow_o
//   busy_o                   high whenever not IDLE
module fpu_mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int MODE_WIDTH = 1,
    parameter logic [MODE_WIDTH-1:0] MODE_ADD = MODE_WIDTH'(0),
    parameter logic [MODE_WIDTH-1:0] MODE_MUL = MODE_WIDTH'(1),
    parameter int LEN_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  pair_valid_i,
    output logic                  pair_ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [MODE_WIDTH-1:0] fpu_mode_o,
    output logic [DATA_WIDTH-1:0] fpu_in1_o,
    output logic [DATA_WIDTH-1:0] fpu_in2_o,
    input  logic [DATA_WIDTH-1:0] fpu_out_i,
    input  logic                  fpu_overflow_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  res_overflow_o,
    output logic                  busy_o
);
    typedef enum logic [2:0] {IDLE, FETCH, MUL, ADD, DONE} state_t;
    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q, cnt_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, prod_q, acc_q;
    logic                  ovf_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            len_q  <= '0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    len_q <= len_i;
                    cnt_q <= '0;
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                    state <= (len_i != '0) ? FETCH : DONE;
                end
                FETCH: if (pair_valid_i) begin
                    a_q   <= a_i;
                    b_q   <= b_i;
                    state <= MUL;
                end
                MUL: begin
                    prod_q <= fpu_out_i;
                    ovf_q  <= ovf_q | fpu_overflow_i;
                    state  <= ADD;
                end
                ADD: begin
                    acc_q <= fpu_out_i;
                    ovf_q <= ovf_q | fpu_overflow_i;
                    cnt_q <= cnt_q + 1'b1;
                    state <= (cnt_q + 1'b1 == len_q) ? DONE : FETCH;
                end
                DONE: if (res_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign pair_ready_o   = state == FETCH;
    assign res_valid_o    = state == DONE;
    assign busy_o         = state != IDLE;
    assign res_o          = acc_q;
    assign res_overflow_o = ovf_q;
    assign fpu_mode_o     = (state == MUL) ? MODE_MUL : MODE_ADD;
    assign fpu_in1_o      = (state == MUL) ? a_q : (state == ADD) ? acc_q : '0;
    assign fpu_in2_o      = (state == MUL) ? b_q : (state == ADD) ? prod_q : '0;
endmodule

// File: tb/tb_fpu_mac_seq.sv
// tb_fpu_mac_seq: randomized self-checking bench for fpu_mac_seq with a behavioural bfloat16 FPU
module tb_fpu_mac_seq;
    logic        clk_i = 0, rst_ni = 1, start_i = 0, pair_valid_i = 0, res_ready_i = 1;
    logic [7:0]  len_i = 0;
    logic [15:0] a_i = 0, b_i = 0;
    logic        pair_ready_o, res_valid_o, res_overflow_o, busy_o, fpu_overflow_i;
    logic [0:0]  fpu_mode_o;
    logic [15:0] fpu_in1_o, fpu_in2_o, fpu_out_i, res_o;
    int          total = 0, bad = 0;
    logic [15:0] pa[$], pb[$];
    int          pulses[$];
    int          done_cyc;
    logic [15:0] got_res;
    logic        got_ovf;

    fpu_mac_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .pair_valid_i(pair_valid_i), .pair_ready_o(pair_ready_o), .a_i(a_i), .b_i(b_i),
        .fpu_mode_o(fpu_mode_o), .fpu_in1_o(fpu_in1_o), .fpu_in2_o(fpu_in2_o),
        .fpu_out_i(fpu_out_i), .fpu_overflow_i(fpu_overflow_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
        .res_overflow_o(res_overflow_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic real p2(int n);
        real r = 1.0;
        for (int i = 0; i < (n < 0 ? -n : n); i++) r = (n < 0) ? r / 2.0 : r * 2.0;
        return r;
    endfunction

    function automatic real bf_to_real(logic [15:0] x);
        real r;
        if (x[14:7] == 8'h00) return 0.0;
        r = (1.0 + real'(x[6:0]) / 128.0) * p2(int'(x[14:7]) - 127);
        return x[15] ? -r : r;
    endfunction

    // Truncating real -> bfloat16 conversion; {overflow, value}
    function automatic logic [16:0] real_to_bf(real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 17'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {1'b1, d[63], 8'hFF, 7'h0};
        if (e <= 0) return {1'b0, d[63], 15'h0};
        return {1'b0, d[63], e[7:0], d[51:45]};
    endfunction

    function automatic logic [16:0] fpu_f(logic [0:0] mode, logic [15:0] x, logic [15:0] y);
        return real_to_bf(mode[0] ? bf_to_real(x) * bf_to_real(y) : bf_to_real(x) + bf_to_real(y));
    endfunction

    assign {fpu_overflow_i, fpu_out_i} = fpu_f(fpu_mode_o, fpu_in1_o, fpu_in2_o);

    // Reference: acc = sum of products, folded in pair order, overflow sticky
    function automatic logic [16:0] mac_model(int n);
        logic [16:0] p, s;
        logic [15:0] acc = 16'h0;
        logic        ovf = 1'b0;
        for (int k = 0; k < n; k++) begin
            p   = fpu_f(1'b1, pa[k], pb[k]);
            s   = fpu_f(1'b0, acc, p[15:0]);
            ovf = ovf | p[16] | s[16];
            acc = s[15:0];
        end
        return {ovf, acc};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic gen_pairs(input int n);
        pa.delete();
        pb.delete();
        for (int k = 0; k < n; k++) begin
            pa.push_back({1'($urandom), 8'($urandom_range(134, 120)), 7'($urandom)});
            pb.push_back({1'($urandom), 8'($urandom_range(134, 120)), 7'($urandom)});
        end
    endtask

    // Starts an accumulation and feeds pa/pb until res_valid_o; cycle 0 is the start-sampling cycle
    task automatic run(input int n, input bit stall, input bit poke);
        int idx = 0, cyc = 0;
        bit hs;
        pulses.delete();
        done_cyc = -1;
        start_i = 1;
        len_i = 8'(n);
        while (cyc < 300) begin
            pair_valid_i = (idx < n) && (!stall || $urandom_range(1, 0) == 1);
            a_i = (idx < n) ? pa[idx] : 16'h0;
            b_i = (idx < n) ? pb[idx] : 16'h0;
            hs = pair_ready_o && pair_valid_i;
            tick();
            cyc++;
            start_i = poke && cyc == 2;
            len_i = 8'($urandom);
            if (hs) idx++;
            if (pair_ready_o) pulses.push_back(cyc);
            if (res_valid_o) begin
                done_cyc = cyc;
                break;
            end
        end
        start_i = 0;
        pair_valid_i = 0;
        got_res = res_o;
        got_ovf = res_overflow_o;
        if (done_cyc < 0) begin
            total++; bad++;
            $display("FAIL run_timeout: res_valid_o never rose within 300 cycles (len=%0d)", n);
        end
    endtask

    task automatic test_reset();
        #2 rst_ni = 0;
        #1;
        total++;
        if ({pair_ready_o, res_valid_o, res_overflow_o, busy_o, fpu_mode_o, res_o, fpu_in1_o, fpu_in2_o} !== 53'h0) begin
            bad++;
            $display("FAIL reset_async: outputs=%h required all zero", {pair_ready_o, res_valid_o, res_overflow_o, busy_o, fpu_mode_o, res_o, fpu_in1_o, fpu_in2_o});
        end
        tick();
        tick();
        total++;
        if ({pair_ready_o, res_valid_o, busy_o, res_o} !== 19'h0) begin
            bad++;
            $display("FAIL reset_held: ready=%b valid=%b busy=%b res=%h required zeros", pair_ready_o, res_valid_o, busy_o, res_o);
        end
        rst_ni = 1;
        tick();
    endtask

    task automatic test_basic();
        pa = '{16'h3F80, 16'h4040};
        pb = '{16'h4000, 16'h3F00};
        run(2, 0, 0);
        total++; if (got_res !== 16'h4060) begin bad++; $display("FAIL basic_res: got %h required 4060", got_res); end
        total++; if (got_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b required 0", got_ovf); end
        total++; if (done_cyc != 7) begin bad++; $display("FAIL basic_latency: got %0d required 7", done_cyc); end
        total++;
        if (pulses.size() != 2 || pulses[0] != 1 || pulses[1] != 4) begin
            bad++;
            $display("FAIL basic_ready_pulses: got %p required '{1,4}", pulses);
        end
        tick();
        total++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || res_o !== 16'h4060) begin
            bad++;
            $display("FAIL basic_idle_hold: valid=%b busy=%b res=%h required 0 0 4060", res_valid_o, busy_o, res_o);
        end
    endtask

    task automatic test_zero_len();
        run(0, 0, 0);
        total++; if (done_cyc != 1) begin bad++; $display("FAIL zero_latency: got %0d required 1", done_cyc); end
        total++; if (got_res !== 16'h0 || got_ovf !== 1'b0) begin bad++; $display("FAIL zero_res: got %h/%b required 0000/0", got_res, got_ovf); end
        total++; if (pulses.size() != 0) begin bad++; $display("FAIL zero_no_ready: got %0d pulses required 0", pulses.size()); end
        tick();
    endtask

    task automatic test_overflow();
        pa = '{16'h7F00};
        pb = '{16'h7F00};
        run(1, 0, 0);
        total++; if (got_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b required 1", got_ovf); end
        tick();
        pa = '{16'h3F80};
        pb = '{16'h3F80};
        run(1, 0, 0);
        total++; if (got_res !== 16'h3F80) begin bad++; $display("FAIL ovf_next_res: got %h required 3f80", got_res); end
        total++; if (got_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared: got %b required 0", got_ovf); end
        tick();
    endtask

    task automatic test_random();
        logic [16:0] exp;
        int n;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(6, 1);
            gen_pairs(n);
            exp = mac_model(n);
            run(n, 0, 0);
            total++; if ({got_ovf, got_res} !== exp) begin bad++; $display("FAIL rand_nostall: got %h required %h (len=%0d)", {got_ovf, got_res}, exp, n); end
            total++; if (done_cyc != 3 * n + 1) begin bad++; $display("FAIL rand_latency: got %0d required %0d", done_cyc, 3 * n + 1); end
            tick();
            run(n, 1, 0);
            total++; if ({got_ovf, got_res} !== exp) begin bad++; $display("FAIL rand_stall: got %h required %h (len=%0d)", {got_ovf, got_res}, exp, n); end
            total++; if (done_cyc < 3 * n + 1) begin bad++; $display("FAIL rand_stall_latency: got %0d required >= %0d", done_cyc, 3 * n + 1); end
            tick();
        end
    endtask

    task automatic test_start_busy();
        logic [16:0] exp;
        gen_pairs(3);
        exp = mac_model(3);
        run(3, 0, 1);
        total++; if ({got_ovf, got_res} !== exp) begin bad++; $display("FAIL busy_start_res: got %h required %h", {got_ovf, got_res}, exp); end
        total++; if (done_cyc != 10) begin bad++; $display("FAIL busy_start_latency: got %0d required 10", done_cyc); end
        tick();
    endtask

    task automatic test_res_backpressure();
        logic [16:0] exp;
        res_ready_i = 0;
        gen_pairs(2);
        exp = mac_model(2);
        run(2, 0, 0);
        total++; if ({got_ovf, got_res} !== exp) begin bad++; $display("FAIL bp_res: got %h required %h", {got_ovf, got_res}, exp); end
        for (int i = 0; i < 5; i++) begin
            start_i = 1;
            len_i = 8'h0;
            tick();
            total++;
            if (res_valid_o !== 1'b1 || res_o !== got_res || res_overflow_o !== got_ovf || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d valid=%b res=%h ovf=%b required 1 %h %b", i, res_valid_o, res_o, res_overflow_o, got_res, got_ovf);
            end
        end
        start_i = 0;
        res_ready_i = 1;
        tick();
        total++; if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL bp_release: valid=%b busy=%b required 0 0", res_valid_o, busy_o); end
    endtask

    task automatic test_done_one_cycle();
        pa = '{16'h4000};
        pb = '{16'h3F80};
        run(1, 0, 0);
        start_i = 1;
        len_i = 8'h0;
        tick();
        total++; if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL done_start_ignored: valid=%b busy=%b required 0 0", res_valid_o, busy_o); end
        tick();
        total++; if (res_valid_o !== 1'b1 || res_o !== 16'h0) begin bad++; $display("FAIL done_start_next: valid=%b res=%h required 1 0000", res_valid_o, res_o); end
        start_i = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [16:0] p;
        gen_pairs(1);
        p = fpu_f(1'b1, pa[0], pb[0]);
        start_i = 1;
        len_i = 8'd4;
        pair_valid_i = 1;
        a_i = pa[0];
        b_i = pb[0];
        tick();
        start_i = 0;
        repeat (5) tick();
        total++;
        if (busy_o !== 1'b1 || fpu_mode_o !== 1'b0 || fpu_in2_o !== p[15:0]) begin
            bad++;
            $display("FAIL mid_in_add: busy=%b mode=%b in2=%h required 1 0 %h", busy_o, fpu_mode_o, fpu_in2_o, p[15:0]);
        end
        rst_ni = 0;
        #1;
        total++;
        if ({pair_ready_o, res_valid_o, res_overflow_o, busy_o, fpu_mode_o, res_o, fpu_in1_o, fpu_in2_o} !== 53'h0) begin
            bad++;
            $display("FAIL mid_reset: outputs=%h required all zero", {pair_ready_o, res_valid_o, res_overflow_o, busy_o, fpu_mode_o, res_o, fpu_in1_o, fpu_in2_o});
        end
        pair_valid_i = 0;
        tick();
        rst_ni = 1;
        tick();
        total++; if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL mid_no_result: valid=%b busy=%b required 0 0", res_valid_o, busy_o); end
        pa = '{16'h4000};
        pb = '{16'h4000};
        run(1, 0, 0);
        total++; if (got_res !== 16'h4080 || got_ovf !== 1'b0) begin bad++; $display("FAIL mid_fresh_run: got %h/%b required 4080/0", got_res, got_ovf); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_random();
        test_start_busy();
        test_res_backpressure();
        test_done_one_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
